alu_exec_ctrl: RTL

- Operand-fetch, execute and writeback sequencer sitting directly upstream of the 8051 core's ALU.
- Accepts one decoded ALU request at a time over a valid/ready handshake, then:
  - reads operands from internal RAM, or takes an immediate;
  - drives the ALU's a/b/op/carry-in inputs and waits the ALU latency;
  - writes the ALU's ans back to RAM and updates the PSW carry flag.

---
 rtl/alu_exec_ctrl_if.sv | 49 ++++
 rtl/alu_exec_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl_if.sv
// Request, RAM and ALU connections of the alu_exec_ctrl sequencer.
// slave = the sequencer itself, master = requester plus attached RAM/ALU.
interface alu_exec_ctrl_if #(
   parameter int AW = 8
);
   // Valid/ready: a request transfers in any cycle where req_valid and req_ready
   // are both high; req_* must be held stable while req_valid waits for ready.
   logic          req_valid;
   logic          req_ready;
   logic [4:0]    req_op;
   logic [AW-1:0] req_src_a;
   logic          req_b_imm;
   logic [AW-1:0] req_src_b;
   logic [7:0]    req_imm;
   logic [AW-1:0] req_dst;
   logic          req_use_cy;
   logic          req_wr_cy;

   logic          ram_re;
   logic [AW-1:0] ram_raddr;
   logic [7:0]    ram_rdata;
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [7:0]    ram_wdata;

   logic [7:0]    alu_a;
   logic [7:0]    alu_b;
   logic [4:0]    alu_op;
   logic          alu_c_in;
   logic [7:0]    alu_ans;
   logic          alu_c_out;

   logic          cy;
   logic          done;

   modport slave (
      input  req_valid, req_op, req_src_a, req_b_imm, req_src_b, req_imm,
             req_dst, req_use_cy, req_wr_cy, ram_rdata, alu_ans, alu_c_out,
      output req_ready, ram_re, ram_raddr, ram_we, ram_waddr, ram_wdata,
             alu_a, alu_b, alu_op, alu_c_in, cy, done
   );

   modport master (
      output req_valid, req_op, req_src_a, req_b_imm, req_src_b, req_imm,
             req_dst, req_use_cy, req_wr_cy, ram_rdata, alu_ans, alu_c_out,
      input  req_ready, ram_re, ram_raddr, ram_we, ram_waddr, ram_wdata,
             alu_a, alu_b, alu_op, alu_c_in, cy, done
   );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Operand fetch / execute / writeback sequencer in front of the 8051 ALU.
// Optional last-writeback forwarding of operand A: define ALU_EXEC_FWD_EN.
module alu_exec_ctrl #(
   parameter int ALU_LAT = 1,
   parameter int AW      = 8
) (
   input  logic             clk,
   input  logic             rst,
   alu_exec_ctrl_if.slave   io_bus,
   output logic [2:0]       o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD_A = 3'd1,
      S_RD_B = 3'd2,
      S_LD_B = 3'd3,
      S_EXEC = 3'd4,
      S_WB   = 3'd5
   } state_t;

   localparam logic [2:0] LAT_INIT = 3'(ALU_LAT - 1);

   state_t        r_state;
   state_t        w_next_state;

   logic          r_cy;
   logic [7:0]    r_a;
   logic [7:0]    r_b;
   logic [4:0]    r_op;
   logic [AW-1:0] r_src_a;
   logic [AW-1:0] r_src_b;
   logic          r_b_imm;
   logic [7:0]    r_imm;
   logic [AW-1:0] r_dst;
   logic          r_use_cy;
   logic          r_wr_cy;
   logic [2:0]    r_lat_cnt;
   logic          r_a_fwd;

   logic          w_accept;
   logic          w_fwd_hit;

`ifdef ALU_EXEC_FWD_EN
   logic          r_fwd_vld;
   logic [AW-1:0] r_fwd_addr;
   logic [7:0]    r_fwd_data;

   // Safe only because no other RAM writer touches addresses this block writes.
   assign w_fwd_hit = r_fwd_vld && (io_bus.req_src_a == r_fwd_addr);
`else
   assign w_fwd_hit = 1'b0;
`endif

   assign w_accept    = (r_state == S_IDLE) && io_bus.req_valid;
   assign o_dbg_state = r_state;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE: if (w_accept) w_next_state = w_fwd_hit ? S_RD_B : S_RD_A;
         S_RD_A: w_next_state = S_RD_B;
         S_RD_B: w_next_state = S_LD_B;
         S_LD_B: w_next_state = S_EXEC;
         S_EXEC: if (r_lat_cnt == 3'd0) w_next_state = S_WB;
         S_WB:   w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cy      <= 1'b0;
         r_a       <= '0;
         r_b       <= '0;
         r_op      <= '0;
         r_src_a   <= '0;
         r_src_b   <= '0;
         r_b_imm   <= 1'b0;
         r_imm     <= '0;
         r_dst     <= '0;
         r_use_cy  <= 1'b0;
         r_wr_cy   <= 1'b0;
         r_lat_cnt <= '0;
         r_a_fwd   <= 1'b0;
`ifdef ALU_EXEC_FWD_EN
         r_fwd_vld  <= 1'b0;
         r_fwd_addr <= '0;
         r_fwd_data <= '0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op     <= io_bus.req_op;
                  r_src_a  <= io_bus.req_src_a;
                  r_b_imm  <= io_bus.req_b_imm;
                  r_src_b  <= io_bus.req_src_b;
                  r_imm    <= io_bus.req_imm;
                  r_dst    <= io_bus.req_dst;
                  r_use_cy <= io_bus.req_use_cy;
                  r_wr_cy  <= io_bus.req_wr_cy;
                  r_a_fwd  <= w_fwd_hit;
`ifdef ALU_EXEC_FWD_EN
                  if (w_fwd_hit) r_a <= r_fwd_data;
`endif
               end
            end
            // RAM data for operand A arrives one cycle after the RD_A strobe.
            S_RD_B: if (!r_a_fwd) r_a <= io_bus.ram_rdata;
            S_LD_B: begin
               r_b       <= r_b_imm ? r_imm : io_bus.ram_rdata;
               r_lat_cnt <= LAT_INIT;
            end
            S_EXEC: if (r_lat_cnt != 3'd0) r_lat_cnt <= r_lat_cnt - 3'd1;
            S_WB: begin
               if (r_wr_cy) r_cy <= io_bus.alu_c_out;
`ifdef ALU_EXEC_FWD_EN
               r_fwd_vld  <= 1'b1;
               r_fwd_addr <= r_dst;
               r_fwd_data <= io_bus.alu_ans;
`endif
            end
            default: ;
         endcase
      end
   end

   assign io_bus.cy = r_cy;

   // Outputs are pure state decodes, forced quiet while rst is high so an
   // aborted operation never writes RAM or pulses done.
   always_comb begin
      io_bus.req_ready = 1'b0;
      io_bus.ram_re    = 1'b0;
      io_bus.ram_raddr = '0;
      io_bus.ram_we    = 1'b0;
      io_bus.ram_waddr = '0;
      io_bus.ram_wdata = '0;
      io_bus.alu_a     = '0;
      io_bus.alu_b     = '0;
      io_bus.alu_op    = '0;
      io_bus.alu_c_in  = 1'b0;
      io_bus.done      = 1'b0;
      if (!rst) begin
         unique case (r_state)
            S_IDLE: io_bus.req_ready = 1'b1;
            S_RD_A: begin
               io_bus.ram_re    = 1'b1;
               io_bus.ram_raddr = r_src_a;
            end
            S_RD_B: begin
               if (!r_b_imm) begin
                  io_bus.ram_re    = 1'b1;
                  io_bus.ram_raddr = r_src_b;
               end
            end
            S_EXEC, S_WB: begin
               io_bus.alu_a    = r_a;
               io_bus.alu_b    = r_b;
               io_bus.alu_op   = r_op;
               io_bus.alu_c_in = r_use_cy & r_cy;
               if (r_state == S_WB) begin
                  io_bus.ram_we    = 1'b1;
                  io_bus.ram_waddr = r_dst;
                  io_bus.ram_wdata = io_bus.alu_ans;
                  io_bus.done      = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
